debounce_fsm: RTL and testbench
===============================

DEBOUNCE_FSM -- requirements
Module: debounce_fsm

Interface
REQ-001 Parameter STABLE_COUNT, default 4: number of consecutive sample ticks at a new level needed to accept it; legal range 2..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_a  input  1  asynchronous, active-low reset; the design has one clock only.
REQ-004 tick  input  1  one-clk-wide sample strobe from the upstream tick counter; any cycle spacing is legal, including back-to-back.
REQ-005 btn_in  input  1  raw, asynchronous, bouncing button level; 1 = pressed.
REQ-006 btn_level  output  1  debounced button level.
REQ-007 press_pulse  output  1  one-clk pulse when an accepted 0->1 transition occurs.
REQ-008 release_pulse  output  1  one-clk pulse when an accepted 1->0 transition occurs.
REQ-009 busy  output  1  high while a candidate transition is being qualified (states WAIT_HIGH or WAIT_LOW).

Function
REQ-010 The block SHALL pass btn_in through a 2-flop synchronizer; the second flop output (sample) SHALL be the only input the FSM sees.
REQ-011 The FSM SHALL have exactly four states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-012 The FSM and the 4-bit qualify counter cnt SHALL change only on cycles with tick=1; with tick=0 they hold.
REQ-013 IDLE_LOW with tick and sample=1: the FSM SHALL go to WAIT_HIGH with cnt=1; with sample=0 it stays in IDLE_LOW.
REQ-014 WAIT_HIGH with tick and sample=0: the FSM SHALL return to IDLE_LOW with cnt=0 and produce no pulse.
REQ-015 WAIT_HIGH with tick, sample=1, and cnt<STABLE_COUNT-1: cnt SHALL increment.
REQ-016 WAIT_HIGH with tick, sample=1, and cnt=STABLE_COUNT-1: the FSM SHALL go to IDLE_HIGH with cnt=0, set btn_level=1, and assert press_pulse for exactly one cycle.
REQ-017 IDLE_HIGH, WAIT_LOW and release_pulse SHALL mirror REQ-013..016 with sample polarity inverted.
REQ-018 btn_level, press_pulse and release_pulse SHALL be registered. They SHALL change on the clock edge that samples the qualifying tick.
REQ-019 Latency: from the first qualifying tick to the btn_level change SHALL be exactly STABLE_COUNT ticks, with the edge on the last one. The synchronizer adds 2 clk before a btn_in change is visible to the FSM.
REQ-020 press_pulse and release_pulse SHALL never be high together, and each SHALL be high for at most one cycle per accepted transition.
REQ-021 Back-to-back ticks SHALL be treated identically to spaced ticks; no tick SHALL be dropped or double-counted.
REQ-022 cnt SHALL never exceed STABLE_COUNT-1; no wrap-around is possible.
REQ-023 busy SHALL be 1 exactly when the state is WAIT_HIGH or WAIT_LOW.

Reset
REQ-024 On rst_a=0, immediately and regardless of clk, the block SHALL clear:
 - synchronizer flops=0
 - state=IDLE_LOW, cnt=0
 - btn_level=0, press_pulse=0, release_pulse=0, busy=0
REQ-025 Reset asserted mid-qualification SHALL discard the partial count. A pulse in flight SHALL be cleared and SHALL NOT be re-issued after reset release.
REQ-026 After rst_a rises, if btn_in is held at 1, the FSM SHALL qualify from IDLE_LOW as a fresh press.

Verification
REQ-027 Bench setup: STABLE_COUNT=4, tick every 10 clk. Hold btn_in=1 -> btn_level rises on the 4th tick after sample goes high, with press_pulse high for exactly 1 clk and busy high for 3 tick periods beforehand.
REQ-028 Bounce: btn_in toggles 1/0 across the first 3 ticks, then holds 1 -> no pulse during bouncing; the press is accepted 4 ticks after the last 0 sample.
REQ-029 Release: from IDLE_HIGH, hold btn_in=0 -> release_pulse for 1 clk and btn_level=0 on the 4th tick; press_pulse stays 0 throughout.
REQ-030 Sample glitch: sample=0 on the 3rd tick of WAIT_HIGH -> back to IDLE_LOW, cnt=0, busy=0, btn_level stays 0.
REQ-031 Reset mid-qualification: assert rst_a=0 in WAIT_HIGH with cnt=2 -> all outputs 0 asynchronously. Release reset with btn_in=1 -> press is accepted after 4 ticks plus the 2-clk sync delay.
REQ-032 Tick every clk (tick held 1): a press is accepted 4 clk after sample rises, confirming no ticks are dropped.

Source files
------------

// File: rtl/debounce_fsm_if.sv
// ============================================================================
// Module   : debounce_fsm_if
// Purpose  : Bundles the sample strobe, raw button level and the debounced
//            outputs of debounce_fsm into one connection.
// Ports    : (interface signals)
//            tick          - one-clk sample strobe from the upstream tick counter
//            btn_in        - raw, asynchronous, bouncing button level (1 = pressed)
//            btn_level     - debounced button level
//            press_pulse   - one-clk pulse on an accepted 0->1 transition
//            release_pulse - one-clk pulse on an accepted 1->0 transition
//            busy          - high while a candidate transition is being qualified
// Modports : master - drives tick/btn_in, observes the debounced outputs
//            slave  - the debouncer itself
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface debounce_fsm_if;
  logic tick;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic busy;

  modport master (
    output tick,
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  busy
  );

  modport slave (
    input  tick,
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/debounce_fsm.sv
// ============================================================================
// Module   : debounce_fsm
// Purpose  : Button debouncer. The raw level is synchronised with two flops,
//            then a four-state FSM accepts a new level only after it has been
//            seen on STABLE_COUNT consecutive sample ticks. Accepted edges
//            produce a registered one-clk press or release pulse.
// Params   : STABLE_COUNT - consecutive ticks needed to accept a level (2..15)
// Ports    : clk   - system clock, rising edge
//            rst_a - asynchronous, active-low reset
//            bus   - debounce_fsm_if.slave (tick, btn_in, btn_level,
//                    press_pulse, release_pulse, busy)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_fsm #(
  parameter int STABLE_COUNT = 4
) (
  input  logic           clk,
  input  logic           rst_a,
  debounce_fsm_if.slave  bus
);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  // Count value at which the next agreeing tick completes qualification.
  localparam logic [3:0] LAST_CNT  = 4'(STABLE_COUNT - 1);

  logic       sync_meta;
  logic       sample;
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       level;
  logic       level_nxt;
  logic       press;
  logic       press_nxt;
  logic       release_p;
  logic       release_nxt;

  // Two-flop synchroniser; only 'sample' is visible to the FSM.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      sync_meta <= 1'b0;
      sample    <= 1'b0;
    end else begin
      sync_meta <= bus.btn_in;
      sample    <= sync_meta;
    end
  end

  // Next-state logic. Everything holds unless tick is high; the pulses
  // default low so each accepted transition yields exactly one cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (bus.tick) begin
      case (state)
        IDLE_LOW: begin
          if (sample) begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = 4'd1;
          end
        end
        WAIT_HIGH: begin
          if (!sample) begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = 4'd0;
          end else if (cnt == LAST_CNT) begin
            state_nxt = IDLE_HIGH;
            cnt_nxt   = 4'd0;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt   = cnt + 4'd1;
          end
        end
        IDLE_HIGH: begin
          if (!sample) begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = 4'd1;
          end
        end
        WAIT_LOW: begin
          if (sample) begin
            state_nxt = IDLE_HIGH;
            cnt_nxt   = 4'd0;
          end else if (cnt == LAST_CNT) begin
            state_nxt   = IDLE_LOW;
            cnt_nxt     = 4'd0;
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt     = cnt + 4'd1;
          end
        end
        default: begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state     <= IDLE_LOW;
      cnt       <= 4'd0;
      level     <= 1'b0;
      press     <= 1'b0;
      release_p <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      level     <= level_nxt;
      press     <= press_nxt;
      release_p <= release_nxt;
    end
  end

  assign bus.btn_level     = level;
  assign bus.press_pulse   = press;
  assign bus.release_pulse = release_p;
  assign bus.busy          = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

`default_nettype wire

// File: tb/tb_debounce_fsm.sv
// ============================================================================
// Module   : tb_debounce_fsm
// Purpose  : Self-checking bench for debounce_fsm (STABLE_COUNT = 4). A
//            behavioural run-length model is compared every cycle; directed
//            scenarios add hand-computed latency and level expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_fsm;

  localparam int SC = 4;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;

  debounce_fsm_if bus ();

  debounce_fsm #(.STABLE_COUNT(SC)) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int tp          = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: the synchroniser is a 2-stage delay; the debouncer
  // accepts the opposite level once it has been seen on SC consecutive ticks.
  // --------------------------------------------------------------------------
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0, m_press = 1'b0, m_release = 1'b0;
  int   m_run = 0;

  initial begin : compare
    forever begin
      @(posedge clk or negedge rst_a);
      if (!rst_a) begin
        m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_release = 0; m_run = 0;
      end else begin
        m_press   = 0;
        m_release = 0;
        if (bus.tick) begin
          if (m_s2 != m_level) begin
            m_run++;
            if (m_run == SC) begin
              m_level = ~m_level;
              m_run   = 0;
              if (m_level) m_press = 1; else m_release = 1;
            end
          end else begin
            m_run = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = bus.btn_in;
      end
      #1;
      check("cycle {level,press,release,busy}",
            {28'd0, bus.btn_level, bus.press_pulse, bus.release_pulse, bus.busy},
            {28'd0, m_level, m_press, m_release, (m_run != 0)});
    end
  end

  // One clock: returns at the negedge, with tick set for the next posedge.
  task automatic clk1();
    @(negedge clk);
    cyc++;
    bus.tick = (cyc % tp == 0);
  endtask

  // Return at the negedge just after a posedge that carried a tick.
  task automatic sync_after_tick();
    int g = 0;
    do begin
      clk1();
      g++;
    end while (!bus.tick && g < 100);
    clk1();
  endtask

  task automatic wait_pulse(input bit want_press, input int budget,
                            output int lat, output int busy_n, output int wrong);
    lat = -1; busy_n = 0; wrong = 0;
    for (int i = 1; i <= budget; i++) begin
      clk1();
      if (bus.busy) busy_n++;
      if (want_press ? bus.release_pulse : bus.press_pulse) wrong++;
      if (want_press ? bus.press_pulse : bus.release_pulse) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int lat, bn, wr, pc;

  initial begin : stim
    bus.tick   = 1'b0;
    bus.btn_in = 1'b0;
    #1;
    check("reset outputs", {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.busy}, 4'b0000);
    repeat (3) clk1();
    rst_a = 1'b1;
    repeat (20) clk1();
    check("idle level", bus.btn_level, 0);
    check("idle busy", bus.busy, 0);

    // Clean press, tick every 10 clk: 4th tick = 40 clk after the change.
    sync_after_tick();
    bus.btn_in = 1'b1;
    wait_pulse(1, 60, lat, bn, wr);
    check("press latency", lat, 40);
    check("press busy clks", bn, 30);
    check("press wrong pulse", wr, 0);
    check("press level", bus.btn_level, 1);
    clk1();
    check("press width", bus.press_pulse, 0);

    // Clean release.
    sync_after_tick();
    bus.btn_in = 1'b0;
    wait_pulse(0, 60, lat, bn, wr);
    check("release latency", lat, 40);
    check("release no press", wr, 0);
    check("release level", bus.btn_level, 0);
    clk1();
    check("release width", bus.release_pulse, 0);

    // Bounce: ticks see 1,0,1,0, then the level holds 1.
    sync_after_tick();
    pc = 0;
    for (int i = 0; i < 4; i++) begin
      bus.btn_in = (i % 2 == 0);
      repeat (10) begin
        clk1();
        if (bus.press_pulse || bus.release_pulse) pc++;
      end
    end
    check("bounce pulses", pc, 0);
    check("bounce busy", bus.busy, 0);
    bus.btn_in = 1'b1;
    wait_pulse(1, 60, lat, bn, wr);
    check("bounce press latency", lat, 40);

    // Back to low, then a glitch on the 3rd tick of qualification.
    sync_after_tick();
    bus.btn_in = 1'b0;
    wait_pulse(0, 60, lat, bn, wr);
    check("release2 latency", lat, 40);
    sync_after_tick();
    bus.btn_in = 1'b1;
    repeat (20) clk1();
    check("glitch busy before", bus.busy, 1);
    bus.btn_in = 1'b0;
    repeat (10) clk1();
    check("glitch busy after", bus.busy, 0);
    check("glitch level", bus.btn_level, 0);
    pc = 0;
    repeat (50) begin
      clk1();
      if (bus.press_pulse || bus.btn_level) pc++;
    end
    check("glitch no press", pc, 0);

    // Reset in WAIT_HIGH with two ticks counted.
    sync_after_tick();
    bus.btn_in = 1'b1;
    repeat (20) clk1();
    check("prereset busy", bus.busy, 1);
    #2 rst_a = 1'b0;
    #1;
    check("async reset outputs", {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.busy}, 4'b0000);
    repeat (3) clk1();
    sync_after_tick();
    rst_a = 1'b1;
    wait_pulse(1, 60, lat, bn, wr);
    check("post-reset press latency", lat, 40);

    sync_after_tick();
    bus.btn_in = 1'b0;
    wait_pulse(0, 60, lat, bn, wr);
    check("release3 latency", lat, 40);

    // Tick held high every clk: sample rises 2 clk after btn_in, accept 4 clk later.
    tp = 1;
    repeat (4) clk1();
    bus.btn_in = 1'b1;
    wait_pulse(1, 20, lat, bn, wr);
    check("fast press latency", lat, 6);
    check("fast press busy clks", bn, 3);
    bus.btn_in = 1'b0;
    wait_pulse(0, 20, lat, bn, wr);
    check("fast release latency", lat, 6);
    repeat (5) clk1();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
